// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: turns the 1 Hz tick into sec/min/hour increment pulses
// and runs the time-set mode FSM from two debounced push-buttons.

module clock_set_ctrl_btn #(
    parameter int DEBOUNCE = 4
) (
    input  logic inclk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          prev_q;
    logic          press_q;

    // two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // count consecutive samples that disagree with the accepted level
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = ~lvl_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // debounced level and disagreement counter
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    // a rising debounced level becomes a one-cycle press strobe
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= lvl_q;
            press_q <= lvl_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

module clock_set_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int BLINK_DIV = 1
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic [5:0] sec_val,
    input  logic [5:0] min_val,
    output logic       sec_inc,
    output logic       sec_clr,
    output logic       min_inc,
    output logic       hour_inc,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    localparam int DW =
        (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

    state_t        state_q;
    state_t        state_d;
    logic          mode_press;
    logic          up_press;
    logic          enter;
    logic          sec_inc_q;
    logic          sec_inc_d;
    logic          sec_clr_q;
    logic          sec_clr_d;
    logic          min_inc_q;
    logic          min_inc_d;
    logic          hour_inc_q;
    logic          hour_inc_d;
    logic          blink_q;
    logic          blink_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    clock_set_ctrl_btn #(
        .DEBOUNCE(DEBOUNCE)
    ) u_btn_mode (
        .inclk  (inclk),
        .rst    (rst),
        .btn_i  (btn_mode),
        .press_o(mode_press)
    );

    clock_set_ctrl_btn #(
        .DEBOUNCE(DEBOUNCE)
    ) u_btn_up (
        .inclk  (inclk),
        .rst    (rst),
        .btn_i  (btn_up),
        .press_o(up_press)
    );

    // mode FSM state register
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // mode press cycles RUN -> SET_HOUR -> SET_MIN -> RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mode_press) state_d = SET_HOUR;
            SET_HOUR: if (mode_press) state_d = SET_MIN;
            SET_MIN:  if (mode_press) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // pulse decode; a mode press swallows a coincident up press
    always_comb begin
        sec_inc_d  = 1'b0;
        sec_clr_d  = 1'b0;
        min_inc_d  = 1'b0;
        hour_inc_d = 1'b0;
        unique case (state_q)
            RUN: begin
                sec_inc_d  = tick;
                min_inc_d  = tick && (sec_val == 6'd59);
                hour_inc_d = tick && (sec_val == 6'd59)
                                  && (min_val == 6'd59);
            end
            SET_HOUR: begin
                hour_inc_d = up_press && !mode_press;
            end
            SET_MIN: begin
                min_inc_d = up_press && !mode_press;
                sec_clr_d = mode_press;
            end
            default: begin
                sec_inc_d = 1'b0;
            end
        endcase
    end

    assign enter = (state_d != state_q) && (state_d != RUN);

    // blink phase: forced low in RUN, restarts high on set entry
    always_comb begin
        blink_d = blink_q;
        div_d   = div_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
            div_d   = '0;
        end else if (enter) begin
            blink_d = 1'b1;
            div_d   = '0;
        end else if (tick) begin
            if (div_q == DIV_LAST) begin
                blink_d = ~blink_q;
                div_d   = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // registered outputs and blink divider
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            sec_inc_q  <= 1'b0;
            sec_clr_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            blink_q    <= 1'b0;
            div_q      <= '0;
        end else begin
            sec_inc_q  <= sec_inc_d;
            sec_clr_q  <= sec_clr_d;
            min_inc_q  <= min_inc_d;
            hour_inc_q <= hour_inc_d;
            blink_q    <= blink_d;
            div_q      <= div_d;
        end
    end

    assign sec_inc  = sec_inc_q;
    assign sec_clr  = sec_clr_q;
    assign min_inc  = min_inc_q;
    assign hour_inc = hour_inc_q;
    assign mode     = state_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and randomized bench for clock_set_ctrl
// against a behavioural model of the tick, button and set-mode rules.

module tb_clock_set_ctrl;
    localparam int DEB  = 4;
    localparam int BDIV = 1;

    logic       inclk    = 1'b0;
    logic       rst      = 1'b0;
    logic       tick     = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic [5:0] sec_val  = '0;
    logic [5:0] min_val  = '0;
    logic       sec_inc;
    logic       sec_clr;
    logic       min_inc;
    logic       hour_inc;
    logic [1:0] mode;
    logic       blink;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 inclk = ~inclk;

    clock_set_ctrl #(
        .DEBOUNCE (DEB),
        .BLINK_DIV(BDIV)
    ) dut (
        .inclk   (inclk),
        .rst     (rst),
        .tick    (tick),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .sec_val (sec_val),
        .min_val (min_val),
        .sec_inc (sec_inc),
        .sec_clr (sec_clr),
        .min_inc (min_inc),
        .hour_inc(hour_inc),
        .mode    (mode),
        .blink   (blink)
    );

    // model: raw button history, accepted levels, scheduled presses
    logic [15:0] h_m;
    logic [15:0] h_u;
    bit          lv_m;
    bit          lv_u;
    int          cyc;
    int          q_m[$];
    int          q_u[$];
    int          m_st;
    bit          m_blk;
    int          m_div;
    bit          e_si;
    bit          e_sc;
    bit          e_mi;
    bit          e_hi;

    int t_si;
    int t_sc;
    int t_mi;
    int t_hi;
    int t_bad;
    int first_hi;
    int t_idx;
    logic [5:0] g_sv = '0;
    logic [5:0] g_mv = '0;

    function automatic logic [6:0] got_v();
        return {mode, blink, sec_inc, sec_clr, min_inc, hour_inc};
    endfunction

    function automatic logic [6:0] exp_v();
        return {2'(m_st), m_blk, e_si, e_sc, e_mi, e_hi};
    endfunction

    function automatic void model_reset();
        h_m   = '0;
        h_u   = '0;
        lv_m  = 1'b0;
        lv_u  = 1'b0;
        cyc   = 0;
        q_m.delete();
        q_u.delete();
        m_st  = 0;
        m_blk = 1'b0;
        m_div = 0;
        {e_si, e_sc, e_mi, e_hi} = '0;
    endfunction

    // level accepted once DEB synchronized samples all disagree;
    // the sample seen at an edge is the raw value two edges earlier
    function automatic bit flips(logic [15:0] h, bit lv);
        for (int j = 2; j < DEB + 2; j++)
            if (h[j] == lv) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(
        bit t, bit bm, bit bu, logic [5:0] sv, logic [5:0] mv);
        bit pm;
        bit pu;
        int nst;
        pm = (q_m.size() > 0) && (q_m[0] == cyc);
        if (pm) void'(q_m.pop_front());
        pu = (q_u.size() > 0) && (q_u[0] == cyc);
        if (pu) void'(q_u.pop_front());
        h_m = {h_m[14:0], bm};
        h_u = {h_u[14:0], bu};
        if (flips(h_m, lv_m)) begin
            lv_m = !lv_m;
            if (lv_m) q_m.push_back(cyc + 2);
        end
        if (flips(h_u, lv_u)) begin
            lv_u = !lv_u;
            if (lv_u) q_u.push_back(cyc + 2);
        end
        {e_si, e_sc, e_mi, e_hi} = '0;
        nst = m_st;
        if (m_st == 0) begin
            if (t) begin
                e_si = 1'b1;
                e_mi = (sv == 59);
                e_hi = (sv == 59) && (mv == 59);
            end
            if (pm) nst = 1;
        end else if (m_st == 1) begin
            if (pm) nst = 2;
            else if (pu) e_hi = 1'b1;
        end else begin
            if (pm) begin
                nst  = 0;
                e_sc = 1'b1;
            end else if (pu) begin
                e_mi = 1'b1;
            end
        end
        if (nst == 0) begin
            m_blk = 1'b0;
            m_div = 0;
        end else if (nst != m_st) begin
            m_blk = 1'b1;
            m_div = 0;
        end else if (t) begin
            m_div++;
            if (m_div == BDIV) begin
                m_blk = !m_blk;
                m_div = 0;
            end
        end
        m_st = nst;
        cyc++;
    endfunction

    task automatic step(input bit t, input bit bm, input bit bu,
                        input logic [5:0] sv, input logic [5:0] mv);
        @(negedge inclk);
        tick     = t;
        btn_mode = bm;
        btn_up   = bu;
        sec_val  = sv;
        min_val  = mv;
        @(posedge inclk);
        model_edge(t, bm, bu, sv, mv);
        #1;
    endtask

    task automatic clr();
        t_si = 0;
        t_sc = 0;
        t_mi = 0;
        t_hi = 0;
        t_bad = 0;
        first_hi = -1;
        t_idx = 0;
    endtask

    task automatic drive(input bit bm, input bit bu,
                         input bit t, input int n);
        for (int i = 0; i < n; i++) begin
            step(t, bm, bu, g_sv, g_mv);
            if (got_v() !== exp_v()) t_bad++;
            t_si += int'(sec_inc);
            t_sc += int'(sec_clr);
            t_mi += int'(min_inc);
            t_hi += int'(hour_inc);
            if (hour_inc === 1'b1 && first_hi < 0) first_hi = t_idx;
            t_idx++;
        end
    endtask

    task automatic press_mode();
        drive(1'b1, 1'b0, 1'b0, 8);
        drive(1'b0, 1'b0, 1'b0, 8);
    endtask

    task automatic press_up();
        drive(1'b0, 1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 1'b0, 8);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge inclk);
        #1;
        n_chk++;
        if (got_v() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0000000", got_v());
        end
        @(negedge inclk);
        rst = 1'b1;
        model_reset();
        clr();
        drive(1'b0, 1'b0, 1'b0, 20);
        n_chk++;
        if (t_si + t_sc + t_mi + t_hi !== 0) begin
            n_fail++;
            $display("FAIL reset_release: got %0d pulses want 0",
                     t_si + t_sc + t_mi + t_hi);
        end
    endtask

    task automatic test_run_cascade();
        step(1'b1, 1'b0, 1'b0, 6'd59, 6'd59);
        n_chk++;
        if (got_v() !== 7'b0001011) begin
            n_fail++;
            $display("FAIL cascade_59_59: got %b want 0001011", got_v());
        end
        step(1'b0, 1'b0, 1'b0, 6'd59, 6'd59);
        n_chk++;
        if (got_v() !== 7'b0000000) begin
            n_fail++;
            $display("FAIL cascade_one_cycle: got %b want 0000000", got_v());
        end
        step(1'b1, 1'b0, 1'b0, 6'd59, 6'd10);
        n_chk++;
        if (got_v() !== 7'b0001010) begin
            n_fail++;
            $display("FAIL cascade_59_10: got %b want 0001010", got_v());
        end
        step(1'b1, 1'b0, 1'b0, 6'd30, 6'd59);
        n_chk++;
        if (got_v() !== 7'b0001000) begin
            n_fail++;
            $display("FAIL cascade_30: got %b want 0001000", got_v());
        end
        step(1'b1, 1'b0, 1'b0, 6'd60, 6'd59);
        n_chk++;
        if (got_v() !== 7'b0001000) begin
            n_fail++;
            $display("FAIL out_of_range_60: got %b want 0001000", got_v());
        end
        step(1'b1, 1'b0, 1'b0, 6'd58, 6'd59);
        n_chk++;
        if (got_v() !== 7'b0001000) begin
            n_fail++;
            $display("FAIL back_to_back: got %b want 0001000", got_v());
        end
        step(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    endtask

    task automatic test_mode_cycle();
        clr();
        g_sv = 6'd59;
        g_mv = 6'd59;
        press_mode();
        n_chk++;
        if ({mode, blink} !== 3'b011) begin
            n_fail++;
            $display("FAIL mode_to_hour: got %b want 011", {mode, blink});
        end
        drive(1'b0, 1'b0, 1'b1, 4);
        press_mode();
        n_chk++;
        if (mode !== 2'b10) begin
            n_fail++;
            $display("FAIL mode_to_min: got %b want 10", mode);
        end
        n_chk++;
        if (t_sc !== 0) begin
            n_fail++;
            $display("FAIL early_sec_clr: got %0d want 0", t_sc);
        end
        drive(1'b0, 1'b0, 1'b1, 4);
        press_mode();
        n_chk++;
        if ({mode, blink} !== 3'b000) begin
            n_fail++;
            $display("FAIL mode_to_run: got %b want 000", {mode, blink});
        end
        n_chk++;
        if (t_sc !== 1) begin
            n_fail++;
            $display("FAIL sec_clr_count: got %0d want 1", t_sc);
        end
        n_chk++;
        if (t_si + t_mi + t_hi !== 0) begin
            n_fail++;
            $display("FAIL set_ticks_ignored: got %0d want 0",
                     t_si + t_mi + t_hi);
        end
        n_chk++;
        if (t_bad !== 0) begin
            n_fail++;
            $display("FAIL mode_cycle_model: got %0d bad want 0", t_bad);
        end
        g_sv = 6'd0;
        g_mv = 6'd0;
    endtask

    task automatic test_set_blink();
        press_mode();
        press_mode();
        n_chk++;
        if ({mode, blink} !== 3'b101) begin
            n_fail++;
            $display("FAIL blink_entry: got %b want 101", {mode, blink});
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        n_chk++;
        if (blink !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_tick1: got %b want 0", blink);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        n_chk++;
        if (blink !== 1'b1) begin
            n_fail++;
            $display("FAIL blink_tick2: got %b want 1", blink);
        end
        clr();
        for (int k = 0; k < 5; k++) press_up();
        n_chk++;
        if (t_mi !== 5 || t_hi !== 0) begin
            n_fail++;
            $display("FAIL set_min_ups: got min %0d hour %0d want 5 0",
                     t_mi, t_hi);
        end
        press_mode();
        n_chk++;
        if ({mode, blink} !== 3'b000) begin
            n_fail++;
            $display("FAIL blink_run: got %b want 000", {mode, blink});
        end
        n_chk++;
        if (t_bad !== 0) begin
            n_fail++;
            $display("FAIL set_blink_model: got %0d bad want 0", t_bad);
        end
    endtask

    task automatic test_debounce();
        press_mode();
        clr();
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 15);
        n_chk++;
        if (t_hi !== 0) begin
            n_fail++;
            $display("FAIL glitch_3: got %0d hour_inc want 0", t_hi);
        end
        clr();
        drive(1'b0, 1'b1, 1'b0, 20);
        n_chk++;
        if (t_hi !== 1) begin
            n_fail++;
            $display("FAIL hold_count: got %0d hour_inc want 1", t_hi);
        end
        n_chk++;
        if (first_hi !== 7) begin
            n_fail++;
            $display("FAIL press_latency: got %0d want 7", first_hi);
        end
        drive(1'b0, 1'b0, 1'b0, 10);
        n_chk++;
        if (t_hi !== 1 || t_bad !== 0) begin
            n_fail++;
            $display("FAIL release: got hour %0d bad %0d want 1 0",
                     t_hi, t_bad);
        end
        press_mode();
        press_mode();
    endtask

    task automatic test_collision();
        press_mode();
        clr();
        drive(1'b1, 1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 1'b0, 8);
        n_chk++;
        if (mode !== 2'b10 || t_hi !== 0 || t_mi !== 0) begin
            n_fail++;
            $display("FAIL mode_up_collide: got mode %b hour %0d min %0d",
                     mode, t_hi, t_mi);
        end
        press_mode();
        clr();
        drive(1'b1, 1'b0, 1'b0, 7);
        drive(1'b1, 1'b0, 1'b1, 1);
        n_chk++;
        if ({mode, sec_inc} !== 3'b011) begin
            n_fail++;
            $display("FAIL tick_mode_collide: got %b want 011",
                     {mode, sec_inc});
        end
        drive(1'b0, 1'b0, 1'b0, 8);
        n_chk++;
        if (t_si !== 1 || t_bad !== 0) begin
            n_fail++;
            $display("FAIL collide_model: got sec %0d bad %0d want 1 0",
                     t_si, t_bad);
        end
        press_mode();
        press_mode();
    endtask

    task automatic test_random();
        bit         bm = 1'b0;
        bit         bu = 1'b0;
        bit         t;
        logic [5:0] sv;
        logic [5:0] mv;
        int         shown = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bm = !bm;
            if ($urandom_range(0, 4) == 0) bu = !bu;
            t  = ($urandom_range(0, 2) == 0);
            sv = $urandom_range(0, 1) ? 6'd59
                                      : 6'($urandom_range(0, 58));
            mv = $urandom_range(0, 1) ? 6'd59
                                      : 6'($urandom_range(0, 58));
            step(t, bm, bu, sv, mv);
            n_chk++;
            if (got_v() !== exp_v()) begin
                n_fail++;
                if (shown < 10)
                    $display("FAIL random cyc %0d: got %b want %b",
                             i, got_v(), exp_v());
                shown++;
            end
        end
    endtask

    task automatic test_reset_midop();
        drive(1'b0, 1'b0, 1'b0, 10);
        press_mode();
        drive(1'b0, 1'b1, 1'b0, 2);
        @(posedge inclk);
        #2;
        rst      = 1'b0;
        btn_up   = 1'b0;
        btn_mode = 1'b0;
        tick     = 1'b0;
        #1;
        n_chk++;
        if (got_v() !== 7'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got %b want 0000000", got_v());
        end
        repeat (2) @(posedge inclk);
        @(negedge inclk);
        rst = 1'b1;
        model_reset();
        clr();
        drive(1'b0, 1'b0, 1'b0, 100);
        n_chk++;
        if (t_si + t_sc + t_mi + t_hi !== 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d pulses want 0",
                     t_si + t_sc + t_mi + t_hi);
        end
        n_chk++;
        if ({mode, blink} !== 3'b000 || t_bad !== 0) begin
            n_fail++;
            $display("FAIL post_reset_state: got %b bad %0d want 000 0",
                     {mode, blink}, t_bad);
        end
    endtask

    initial begin
        model_reset();
        clr();
        test_reset();
        test_run_cascade();
        test_mode_cycle();
        test_set_blink();
        test_debounce();
        test_collision();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
